// File: rtl/ysyx_041514_clint_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_041514_clint_bridge
// Purpose  : Bus-slave front end for the core-local timer registers (mtime,
//            mtimecmp). Accepts one uncached MMIO request at a time from the
//            LSU, decodes it, and turns it into single-cycle register
//            operations on the timer block. Partial writes are performed as
//            read-modify-write. Addresses that hit neither register return
//            an error response.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            req_*_i / req_ready_o         - request channel (valid/ready)
//            resp_*_o / resp_ready_i       - response channel (valid/ready)
//            mtime_addr_o                  - register address to the timer block
//            mtime_write_valid_o           - one-cycle write pulse
//            mtime_wdata_o                 - write data to the timer block
//            mtime_rdata_i                 - combinational read data from timer
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_041514_clint_bridge #(
    parameter int                XLEN          = 64,
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] MTIME_ADDR    = 32'h0200_BFF8,
    parameter logic [ADDR_W-1:0] MTIMECMP_ADDR = 32'h0200_4000
) (
    input  logic                clk,
    input  logic                rst,
    // request channel
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic                req_wen_i,
    input  logic [XLEN-1:0]     req_wdata_i,
    input  logic [XLEN/8-1:0]   req_wstrb_i,
    // response channel
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [XLEN-1:0]     resp_rdata_o,
    output logic                resp_err_o,
    // timer block side
    output logic [ADDR_W-1:0]   mtime_addr_o,
    output logic                mtime_write_valid_o,
    output logic [XLEN-1:0]     mtime_wdata_o,
    input  logic [XLEN-1:0]     mtime_rdata_i
);

    localparam int STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e              state_q,   state_d;
    logic                sel_cmp_q, sel_cmp_d;   // 1: mtimecmp, 0: mtime
    logic                rmw_q,     rmw_d;
    logic [XLEN-1:0]     wdata_q,   wdata_d;     // request data, later the merged word
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
    logic [XLEN-1:0]     rdata_q,   rdata_d;
    logic                err_q,     err_d;

    // ------------------------------------------------------------------
    // Address decode: word-granular, byte offset is carried by the strobes
    // ------------------------------------------------------------------
    logic w_hit_mtime;
    logic w_hit_cmp;
    logic w_hit;
    logic w_unused_addr_lsb;

    assign w_hit_mtime = (req_addr_i[ADDR_W-1:3] == MTIME_ADDR[ADDR_W-1:3]);
    assign w_hit_cmp   = (req_addr_i[ADDR_W-1:3] == MTIMECMP_ADDR[ADDR_W-1:3]);
    assign w_hit       = w_hit_mtime | w_hit_cmp;
    assign w_unused_addr_lsb = ^req_addr_i[2:0];

    logic [ADDR_W-1:0] w_reg_addr;
    assign w_reg_addr = sel_cmp_q ? MTIMECMP_ADDR : MTIME_ADDR;

    // ------------------------------------------------------------------
    // Byte merge for read-modify-write: strobed bytes from the request,
    // the rest from the value read back in RD.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_merged;

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_merge
        assign w_merged[gi*8 +: 8] = wstrb_q[gi] ? wdata_q[gi*8 +: 8]
                                                 : mtime_rdata_i[gi*8 +: 8];
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_cmp_q <= 1'b0;
            rmw_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_cmp_q <= sel_cmp_d;
            rmw_q     <= rmw_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d             = state_q;
        sel_cmp_d           = sel_cmp_q;
        rmw_d               = rmw_q;
        wdata_d             = wdata_q;
        wstrb_d             = wstrb_q;
        rdata_d             = rdata_q;
        err_d               = err_q;
        req_ready_o         = 1'b0;
        resp_valid_o        = 1'b0;
        mtime_addr_o        = '0;
        mtime_write_valid_o = 1'b0;
        mtime_wdata_o       = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    sel_cmp_d = w_hit_cmp;
                    wdata_d   = req_wdata_i;
                    wstrb_d   = req_wstrb_i;
                    rmw_d     = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    if (!w_hit) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!req_wen_i) begin
                        state_d = ST_RD;
                    end else if (&req_wstrb_i) begin
                        state_d = ST_WR;
                    end else if (req_wstrb_i == '0) begin
                        // nothing to write: acknowledge without touching the timer
                        state_d = ST_RESP;
                    end else begin
                        rmw_d   = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                mtime_addr_o = w_reg_addr;
                if (rmw_q) begin
                    wdata_d = w_merged;
                    state_d = ST_WR;
                end else begin
                    rdata_d = mtime_rdata_i;
                    state_d = ST_RESP;
                end
            end

            ST_WR: begin
                mtime_addr_o        = w_reg_addr;
                mtime_write_valid_o = 1'b1;
                mtime_wdata_o       = wdata_q;
                state_d             = ST_RESP;
            end

            ST_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    // clear so the response outputs read as zero while idle
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule
`default_nettype wire

// File: doc/ysyx_041514_clint_bridge.md
# ysyx_041514_clint_bridge

Bus-slave front end for the core-local timer registers (mtime, mtimecmp). It sits between the LSU's uncached MMIO request/response port and the timer block, which consumes its address/write-valid/write-data outputs and returns combinational read data. It decodes addresses and serialises each access into single-cycle timer-register operations. Partial writes use byte strobes and are performed as a read-modify-write. Decode misses return an error response.

## Interface
Parameters:
- XLEN, 64, data width; also the width of the timer registers.
- ADDR_W, 32, bus address width.
- MTIME_ADDR, 32'h0200_BFF8, mtime register address (8-byte aligned).
- MTIMECMP_ADDR, 32'h0200_4000, mtimecmp register address (8-byte aligned).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  ADDR_W  byte address.
- req_wen_i  in  1  1=write, 0=read.
- req_wdata_i  in  XLEN  write data, lane-aligned to the 8-byte word.
- req_wstrb_i  in  XLEN/8  byte enables for writes.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when valid&ready.
- resp_rdata_o  out  XLEN  read data (the whole 8-byte word); 0 for writes and errors.
- resp_err_o  out  1  decode error.
- mtime_addr_o  out  ADDR_W  address to the timer block.
- mtime_write_valid_o  out  1  one-cycle write pulse to the timer block.
- mtime_wdata_o  out  XLEN  write data to the timer block.
- mtime_rdata_i  in  XLEN  combinational read data from the timer block.

## Operation
- Decode:
  - Hit when req_addr_i[ADDR_W-1:3] equals MTIME_ADDR[ADDR_W-1:3] or MTIMECMP_ADDR[ADDR_W-1:3].
  - addr[2:0] are ignored; the strobes select the bytes.
  - The decode result and all request fields are latched at acceptance.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready_o=1.
  - On acceptance:
    - Miss → RESP with err=1.
    - Hit read → RD.
    - Hit write with wstrb all-ones → WR.
    - Hit write with a partial, non-zero wstrb → RD (RMW flag set).
    - Hit write with wstrb all-zero → RESP, ok, no timer access.
- RD:
  - mtime_addr_o = latched register address (MTIME_ADDR or MTIMECMP_ADDR).
  - Sample mtime_rdata_i.
  - Plain read: capture into the response data register → RESP.
  - RMW: form the merge, byte i = wstrb[i] ? wdata byte i : rdata byte i; register it → WR.
- WR:
  - mtime_addr_o = latched address.
  - mtime_write_valid_o=1 for exactly this cycle.
  - mtime_wdata_o = full wdata, or the merged value for RMW.
  - Then → RESP.
- RESP:
  - resp_valid_o=1; hold rdata and err stable until resp_ready_i.
  - On handshake → IDLE.
- Outside RD/WR: mtime_addr_o=0, mtime_write_valid_o=0, mtime_wdata_o=0. Address 0 decodes to neither register, so the timer read mux is idle.
- RMW on mtime merges the value sampled in RD. The increment that occurs between RD and WR is overwritten for the written bytes and the unwritten bytes. This is accepted behaviour: software writes mtime with full-width stores.
- Only one transaction is outstanding; there is no pipelining.

## Timing
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, mtime_* outputs=0.
- Reset asserted in any state returns to IDLE on the next edge. Any pending response is dropped and no write pulse is issued.
- Acceptance at edge T. Latency to resp_valid_o high:
  - Error or zero-strobe write: T+1.
  - Read or full write: T+2.
  - Partial write: T+3.
- Read data reflects the mtime value in the RD cycle (the value at the edge ending RD).
- The write takes effect in the timer at the edge ending WR.
- req_ready_o is low from T+1 until the cycle after the response handshake. Back-to-back throughput is one transaction per 3 cycles (reads, resp_ready tied high).
- resp_ready_i low stalls indefinitely in RESP; outputs are stable.

## Test plan
- Reset, then read MTIME_ADDR with resp_ready=1 → resp_valid at T+2, err=0, rdata equals the timer's mtime value in the RD cycle (after 10 cycles of counting from reset, accept at T=10 → rdata=11, i.e. mtime at cycle T+1). req_ready=0 during T+1..T+2.
- Full write MTIMECMP_ADDR, wdata=64'h0000_0000_0000_1000, wstrb=8'hFF → one-cycle mtime_write_valid_o at T+1 with addr=0200_4000. Read-back → 64'h1000.
- Partial write MTIMECMP_ADDR+4, wdata=64'hDEAD_BEEF_0000_0000, wstrb=8'hF0, on mtimecmp=64'h1000 → RD at T+1, WR at T+2 with wdata=64'hDEAD_BEEF_0000_1000, resp at T+3.
- Read 32'h1000_0000 (miss) → resp at T+1, err=1, rdata=0, mtime_write_valid_o never asserted. Write with wstrb=0 to MTIME_ADDR → ok response at T+1, no pulse.
- Hold resp_ready=0 for 5 cycles after a read → resp_valid and rdata held constant while mtime advances, and a new req_valid is not accepted.
- Assert rst during WR of a full write → no response; state IDLE and all outputs at reset values after the edge.
